// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA raster generator.
package vga_pkg;

  localparam int unsigned COLOR_W = 6;
  localparam int unsigned COUNT_W = 10;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [COUNT_W-1:0] count_t;

  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  localparam color_t DEF_BG_COLOR = 6'b000001;

  // Inclusive unsigned range test used for the sync windows.
  function automatic logic in_range(count_t value, count_t lo, count_t hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster bus between the sync generator (master) and the drawer mux / pins (slave).
interface vga_sync_generator_if;
  import vga_pkg::*;

  color_t pixel_data;
  logic   pixel_draw;
  count_t hcount;
  count_t vcount;
  logic   pixel_tick;
  logic   video_on;
  logic   frame_start;
  color_t rgb;
  logic   hsync;
  logic   vsync;

  modport master (
    input  pixel_data, pixel_draw,
    output hcount, vcount, pixel_tick, video_on, frame_start, rgb, hsync, vsync
  );

  modport slave (
    output pixel_data, pixel_draw,
    input  hcount, vcount, pixel_tick, video_on, frame_start, rgb, hsync, vsync
  );

endinterface

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clk pixel strobe every CLK_DIV clocks.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  // With CLK_DIV=1 the counter sits at 0 == DivLast, so the strobe is constant.
  assign pixel_tick_o = (div_q == DivLast);

  always_comb begin
    div_d = pixel_tick_o ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// Raster counters, sync/blank/frame markers and the registered pixel output stage.
module vga_sync_generator
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter color_t      BG_COLOR    = DEF_BG_COLOR
) (
  input logic                  clk,
  input logic                  reset,
  vga_sync_generator_if.master bus
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam count_t HLast      = count_t'(HTotal - 1);
  localparam count_t VLast      = count_t'(VTotal - 1);
  localparam count_t HSyncStart = count_t'(H_VISIBLE + H_FP);
  localparam count_t HSyncEnd   = count_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam count_t VSyncStart = count_t'(V_VISIBLE + V_FP);
  localparam count_t VSyncEnd   = count_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic   pixel_tick;
  logic   video_on;
  count_t hcount_q, hcount_d;
  count_t vcount_q, vcount_d;
  color_t rgb_q, rgb_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   frame_start_q, frame_start_d;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk          (clk),
    .reset        (reset),
    .pixel_tick_o (pixel_tick)
  );

  assign video_on = (hcount_q < count_t'(H_VISIBLE)) && (vcount_q < count_t'(V_VISIBLE));

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;

    if (pixel_tick) begin
      if (hcount_q == HLast) begin
        hcount_d = '0;
        if (vcount_q == VLast) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 1'b1;
        end
      end else begin
        hcount_d = hcount_q + 1'b1;
      end

      // Output stage samples the pre-edge position so rgb and both syncs share one tick of lag.
      rgb_d   = video_on ? (bus.pixel_draw ? bus.pixel_data : BG_COLOR) : '0;
      hsync_d = in_range(hcount_q, HSyncStart, HSyncEnd) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d = in_range(vcount_q, VSyncStart, VSyncEnd) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      rgb_q         <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.hcount      = hcount_q;
  assign bus.vcount      = vcount_q;
  assign bus.pixel_tick  = pixel_tick;
  assign bus.video_on    = video_on;
  assign bus.frame_start = frame_start_q;
  assign bus.rgb         = rgb_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: two shrunken-timing builds (CLK_DIV=3 and 1) against a raster model.
module tb_vga_sync_generator;
  import vga_pkg::*;

  localparam int unsigned HV = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int unsigned VV = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int unsigned HT = HV + HFP + HS + HBP;
  localparam int unsigned VT = VV + VFP + VS + VBP;
  localparam int unsigned FRAME = HT * VT;
  localparam logic SA = 1'b0;
  localparam logic [5:0] BG = 6'h01;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_sync_generator_if bus0 ();
  vga_sync_generator_if bus1 ();

  vga_sync_generator #(
    .CLK_DIV(3), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_ACTIVE(SA), .BG_COLOR(BG)
  ) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  vga_sync_generator #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_ACTIVE(SA), .BG_COLOR(BG)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Model: c counts clk edges since reset; ticks taken = c / div, raster position follows directly.
  int unsigned c = 0;
  logic [5:0]  e_rgb [2];
  logic        e_hs [2];
  logic        e_vs [2];
  int          mode = 0;
  logic [5:0]  d_data = '0;
  logic        d_draw = 1'b0;
  bit          count_en = 1'b0;
  int          hs_cnt [2];
  int          vs_cnt [2];
  int          fs_cnt [2];
  int          passed = 0;
  int          total = 0;
  int          failed = 0;

  function automatic int unsigned div_of(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  task automatic check(string name, int k, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s dut%0d got=%0h expected=%0h (clk %0d after reset)", name, k, got, exp, c);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int unsigned d, t, h, v;
      logic [9:0] o_h, o_v;
      logic [5:0] o_rgb;
      logic o_tick, o_von, o_fs, o_hs, o_vs;
      d = div_of(k);
      t = c / d;
      h = t % HT;
      v = (t / HT) % VT;
      if (k == 0) begin
        o_h = bus0.hcount; o_v = bus0.vcount; o_tick = bus0.pixel_tick; o_von = bus0.video_on;
        o_fs = bus0.frame_start; o_rgb = bus0.rgb; o_hs = bus0.hsync; o_vs = bus0.vsync;
      end else begin
        o_h = bus1.hcount; o_v = bus1.vcount; o_tick = bus1.pixel_tick; o_von = bus1.video_on;
        o_fs = bus1.frame_start; o_rgb = bus1.rgb; o_hs = bus1.hsync; o_vs = bus1.vsync;
      end
      check("hcount", k, 32'(o_h), h);
      check("vcount", k, 32'(o_v), v);
      check("pixel_tick", k, 32'(o_tick), 32'((c % d) == d - 1));
      check("video_on", k, 32'(o_von), 32'(h < HV && v < VV));
      check("frame_start", k, 32'(o_fs), 32'((c % d) == 0 && t > 0 && (t % FRAME) == 0));
      check("rgb", k, 32'(o_rgb), 32'(e_rgb[k]));
      check("hsync", k, 32'(o_hs), 32'(e_hs[k]));
      check("vsync", k, 32'(o_vs), 32'(e_vs[k]));
      if (count_en) begin
        hs_cnt[k] += int'(o_hs == SA);
        vs_cnt[k] += int'(o_vs == SA);
        fs_cnt[k] += int'(o_fs);
      end
    end
  endtask

  // Drive inputs at the negedge, let one clk edge happen, advance the model, then check.
  task automatic cycle(input bit rst);
    reset = rst;
    case (mode)
      1:       begin d_data = 6'h3F;             d_draw = 1'b1; end
      2:       begin d_data = 6'($urandom());    d_draw = 1'b0; end
      default: begin d_data = 6'($urandom());    d_draw = 1'($urandom()); end
    endcase
    bus0.pixel_data = d_data; bus0.pixel_draw = d_draw;
    bus1.pixel_data = d_data; bus1.pixel_draw = d_draw;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int unsigned d, t, h, v;
      d = div_of(k);
      if (rst) begin
        e_rgb[k] = '0; e_hs[k] = ~SA; e_vs[k] = ~SA;
      end else if ((c % d) == d - 1) begin
        t = c / d;
        h = t % HT;
        v = (t / HT) % VT;
        e_rgb[k] = (h < HV && v < VV) ? (d_draw ? d_data : BG) : 6'h00;
        e_hs[k]  = (h >= HV + HFP && h <= HV + HFP + HS - 1) ? SA : ~SA;
        e_vs[k]  = (v >= VV + VFP && v <= VV + VFP + VS - 1) ? SA : ~SA;
      end
    end
    c = rst ? 0 : c + 1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit found;
    bus0.pixel_data = '0; bus0.pixel_draw = 1'b0;
    bus1.pixel_data = '0; bus1.pixel_draw = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hs_cnt[k] = 0; vs_cnt[k] = 0; fs_cnt[k] = 0;
    end
    @(negedge clk);

    // Reset state, then random pixel traffic across several frames.
    mode = 0;
    cycle(1'b1);
    repeat (1000) cycle(1'b0);

    // Solid draw: sync/frame-marker totals over a 2-frame window of the divided build.
    mode = 1;
    count_en = 1'b1;
    cycle(1'b1);
    repeat (2 * FRAME * 3 - 1) cycle(1'b0);
    count_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("hsync_active_clks", k, 32'(hs_cnt[k]), 2 * VT * HS * 3);
      check("vsync_active_clks", k, 32'(vs_cnt[k]), 2 * VS * HT * 3);
      check("frame_start_pulses", k, 32'(fs_cnt[k]), (k == 0) ? 1 : 5);
    end

    // No draw: visible area shows the background colour.
    mode = 2;
    repeat (FRAME * 3) cycle(1'b0);

    // Reset mid-tick while both syncs are active on the divided build.
    mode = 0;
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME * 3 && !found; i++) begin
      if ((c / 3) % HT == HV + HFP + 1 && ((c / 3) / HT) % VT == VV + VFP && c % 3 == 1)
        found = 1'b1;
      else
        cycle(1'b0);
    end
    check("seek_sync_position", 0, 32'(found), 32'd1);
    check("in_hsync_before_reset", 0, 32'(bus0.hsync), 32'(SA));
    cycle(1'b1);
    check("rst_hcount", 0, 32'(bus0.hcount), 32'd0);
    check("rst_vcount", 0, 32'(bus0.vcount), 32'd0);
    check("rst_rgb", 0, 32'(bus0.rgb), 32'd0);
    check("rst_hsync", 0, 32'(bus0.hsync), 32'd1);
    check("rst_vsync", 0, 32'(bus0.vsync), 32'd1);
    check("rst_frame_start", 0, 32'(bus0.frame_start), 32'd0);
    repeat (600) cycle(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
